// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Holds read-mode constants, parameter legality checks and fill arithmetic.
package sync_fifo_pkg;

    localparam int FIFO_STD   = 0;
    localparam int FIFO_FWFT  = 1;
    localparam int MIN_AWIDTH = 1;
    localparam int MAX_AWIDTH = 30;

    function automatic bit params_legal(input int aw, input int fwft,
                                        input int afull, input int aempty);
        bit ok;
        ok = (aw >= MIN_AWIDTH) && (aw <= MAX_AWIDTH);
        ok = ok && (fwft == FIFO_STD || fwft == FIFO_FWFT);
        ok = ok && (afull >= 1) && (afull <= (1 << aw));
        ok = ok && (aempty >= 0) && (aempty <= (1 << aw) - 1);
        return ok;
    endfunction

    // Pointer difference kept to the AWIDTH+1 bit pointer range.
    function automatic logic [31:0] fifo_fill(input logic [31:0] wp,
                                              input logic [31:0] rp,
                                              input int aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (wp - rp) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Register-array storage: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with fill count, threshold flags, sticky error flags
// and a standard or first-word-fall-through read port.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 4,
    parameter int FWFT       = FIFO_STD,
    parameter int AFULL_LVL  = 2**AWIDTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   fill_count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    if (!params_legal(AWIDTH, FWFT, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("sync_fifo_flags: illegal parameter combination");
    end

    localparam logic [AWIDTH:0] AFULL_C  = (AWIDTH+1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] AEMPTY_C = (AWIDTH+1)'(AEMPTY_LVL);

    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DWIDTH-1:0] ram_rdata;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                        (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
    assign fill_count = (AWIDTH+1)'(fifo_fill(32'(wr_ptr_q), 32'(rd_ptr_q), AWIDTH));
    assign almost_full  = (fill_count >= AFULL_C);
    assign almost_empty = (fill_count <= AEMPTY_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr && !fifo_full;
    assign rd_acc = rd && !fifo_empty;

    // A set on the same edge takes priority over err_clr.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AWIDTH+1)'(wr_acc);
        rd_ptr_d    = rd_ptr_q + (AWIDTH+1)'(rd_acc);
        overflow_d  = overflow_q && !err_clr;
        underflow_d = underflow_q && !err_clr;
        if (wr && fifo_full) overflow_d = 1'b1;
        if (rd && fifo_empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .DWIDTH(DWIDTH),
        .AWIDTH(AWIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr_q[AWIDTH-1:0]),
        .wdata(wr_data),
        .raddr(rd_ptr_q[AWIDTH-1:0]),
        .rdata(ram_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign rd_data  = ram_rdata;
        assign rd_valid = !fifo_empty;
    end else begin : g_std
        logic [DWIDTH-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q, rd_valid_d;

        always_comb begin
            rd_data_d  = rd_acc ? ram_rdata : rd_data_q;
            rd_valid_d = rd_acc;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-mode and FWFT-mode instances, depth 4.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    int         n_cmp = 0;
    int         n_err = 0;

    logic       s_wr, s_rd, s_clr;
    logic [7:0] s_wdata, s_rdata;
    logic       s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [2:0] s_cnt;

    logic       f_wr, f_rd, f_clr;
    logic [7:0] f_wdata, f_rdata;
    logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [2:0] f_cnt;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DWIDTH(8), .AWIDTH(2), .FWFT(0), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) dut_s (
        .clk(clk), .rst(rst), .wr(s_wr), .wr_data(s_wdata), .rd(s_rd),
        .rd_data(s_rdata), .rd_valid(s_rvalid), .fifo_full(s_full),
        .fifo_empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
        .fill_count(s_cnt), .overflow(s_ovf), .underflow(s_unf),
        .err_clr(s_clr)
    );

    sync_fifo_flags #(
        .DWIDTH(8), .AWIDTH(2), .FWFT(1), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) dut_f (
        .clk(clk), .rst(rst), .wr(f_wr), .wr_data(f_wdata), .rd(f_rd),
        .rd_data(f_rdata), .rd_valid(f_rvalid), .fifo_full(f_full),
        .fifo_empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
        .fill_count(f_cnt), .overflow(f_ovf), .underflow(f_unf),
        .err_clr(f_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_push(input logic [7:0] d);
        s_wr = 1'b1; s_wdata = d;
        tick();
        s_wr = 1'b0;
    endtask

    task automatic s_pop();
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
    endtask

    task automatic s_clear();
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", s_empty); end
        n_cmp++; if (s_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", s_full); end
        n_cmp++; if (s_cnt !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", s_cnt); end
        n_cmp++; if (s_aempty !== 1'b1) begin n_err++; $display("FAIL rst_aempty: got %b want 1", s_aempty); end
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", s_rvalid); end
        n_cmp++; if (s_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", s_rdata); end
        n_cmp++; if ({s_ovf, s_unf} !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b want 00", {s_ovf, s_unf}); end
        s_push(8'hC1); s_push(8'hC2); s_push(8'hC3);
        n_cmp++; if (s_cnt !== 3'd3) begin n_err++; $display("FAIL pre_rst_count: got %0d want 3", s_cnt); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %b want 1", s_empty); end
        n_cmp++; if (s_cnt !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", s_cnt); end
        n_cmp++; if (s_aempty !== 1'b1) begin n_err++; $display("FAIL midrst_aempty: got %b want 1", s_aempty); end
        n_cmp++; if (s_full !== 1'b0) begin n_err++; $display("FAIL midrst_full: got %b want 0", s_full); end
        tick();
        rst = 1'b0;
        s_pop();
        n_cmp++; if (s_unf !== 1'b1) begin n_err++; $display("FAIL postrst_unf: got %b want 1", s_unf); end
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL postrst_rvalid: got %b want 0", s_rvalid); end
        n_cmp++; if (s_rdata !== 8'h00) begin n_err++; $display("FAIL postrst_rdata: got %h want 00", s_rdata); end
        s_clear();
        n_cmp++; if (s_unf !== 1'b0) begin n_err++; $display("FAIL postrst_clr: got %b want 0", s_unf); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        s_push(8'h11);
        n_cmp++; if (s_aempty !== 1'b1) begin n_err++; $display("FAIL fill_aempty1: got %b want 1", s_aempty); end
        s_push(8'h22);
        n_cmp++; if (s_aempty !== 1'b0) begin n_err++; $display("FAIL fill_aempty2: got %b want 0", s_aempty); end
        n_cmp++; if (s_afull !== 1'b0) begin n_err++; $display("FAIL fill_afull2: got %b want 0", s_afull); end
        s_push(8'h33);
        n_cmp++; if (s_afull !== 1'b1) begin n_err++; $display("FAIL fill_afull3: got %b want 1", s_afull); end
        n_cmp++; if (s_full !== 1'b0) begin n_err++; $display("FAIL fill_full3: got %b want 0", s_full); end
        s_push(8'h44);
        n_cmp++; if (s_full !== 1'b1) begin n_err++; $display("FAIL fill_full4: got %b want 1", s_full); end
        n_cmp++; if (s_cnt !== 3'd4) begin n_err++; $display("FAIL fill_count4: got %0d want 4", s_cnt); end
        n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf_early: got %b want 0", s_ovf); end
        s_push(8'h55);
        n_cmp++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", s_ovf); end
        n_cmp++; if (s_cnt !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", s_cnt); end
        for (int i = 0; i < 4; i++) begin
            s_pop();
            n_cmp++; if (s_rvalid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, s_rvalid); end
            n_cmp++; if (s_rdata !== exp[i]) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, s_rdata, exp[i]); end
            tick();
            n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL drain_pulse[%0d]: got %b want 0", i, s_rvalid); end
        end
        n_cmp++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", s_empty); end
        s_clear();
        n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", s_ovf); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp [5];
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h04; exp[4] = 8'h05;
        s_push(8'h01); s_push(8'h02);
        for (int i = 0; i < 5; i++) begin
            s_wr = 1'b1; s_rd = 1'b1; s_wdata = 8'(8'h03 + i);
            tick();
            n_cmp++; if (s_cnt !== 3'd2) begin n_err++; $display("FAIL sim_count[%0d]: got %0d want 2", i, s_cnt); end
            n_cmp++; if (s_rdata !== exp[i]) begin n_err++; $display("FAIL sim_data[%0d]: got %h want %h", i, s_rdata, exp[i]); end
        end
        s_wr = 1'b0; s_rd = 1'b0;
        s_push(8'h08); s_push(8'h09);
        n_cmp++; if (s_full !== 1'b1) begin n_err++; $display("FAIL sim_full: got %b want 1", s_full); end
        s_wr = 1'b1; s_rd = 1'b1; s_wdata = 8'h0A;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
        n_cmp++; if (s_cnt !== 3'd3) begin n_err++; $display("FAIL simfull_count: got %0d want 3", s_cnt); end
        n_cmp++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL simfull_ovf: got %b want 1", s_ovf); end
        n_cmp++; if (s_rdata !== 8'h06) begin n_err++; $display("FAIL simfull_data: got %h want 06", s_rdata); end
        s_pop();
        n_cmp++; if (s_rdata !== 8'h07) begin n_err++; $display("FAIL simtail0: got %h want 07", s_rdata); end
        s_pop();
        n_cmp++; if (s_rdata !== 8'h08) begin n_err++; $display("FAIL simtail1: got %h want 08", s_rdata); end
        s_pop();
        n_cmp++; if (s_rdata !== 8'h09) begin n_err++; $display("FAIL simtail2: got %h want 09", s_rdata); end
        n_cmp++; if (s_empty !== 1'b1) begin n_err++; $display("FAIL simtail_empty: got %b want 1", s_empty); end
        s_clear();
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 8'(8'h40 + i);
            s_push(d);
            n_cmp++; if ({s_empty, s_full, s_cnt} !== 5'b00001) begin n_err++; $display("FAIL wrap_wflags[%0d]: got %b want 00001", i, {s_empty, s_full, s_cnt}); end
            s_pop();
            n_cmp++; if ({s_rvalid, s_rdata} !== {1'b1, d}) begin n_err++; $display("FAIL wrap_data[%0d]: got %b/%h want 1/%h", i, s_rvalid, s_rdata, d); end
            n_cmp++; if ({s_empty, s_full} !== 2'b10) begin n_err++; $display("FAIL wrap_rflags[%0d]: got %b want 10", i, {s_empty, s_full}); end
        end
    endtask

    task automatic test_underflow();
        s_pop();
        n_cmp++; if (s_unf !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b want 1", s_unf); end
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL unf_valid: got %b want 0", s_rvalid); end
        n_cmp++; if (s_rdata !== 8'h53) begin n_err++; $display("FAIL unf_hold: got %h want 53", s_rdata); end
        tick();
        n_cmp++; if (s_unf !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b want 1", s_unf); end
        s_clear();
        n_cmp++; if (s_unf !== 1'b0) begin n_err++; $display("FAIL unf_clr: got %b want 0", s_unf); end
        s_clr = 1'b1; s_rd = 1'b1;
        tick();
        s_clr = 1'b0; s_rd = 1'b0;
        n_cmp++; if (s_unf !== 1'b1) begin n_err++; $display("FAIL unf_setwins: got %b want 1", s_unf); end
        s_clear();
    endtask

    task automatic test_fwft();
        n_cmp++; if ({f_empty, f_rvalid} !== 2'b10) begin n_err++; $display("FAIL fw_idle: got %b want 10", {f_empty, f_rvalid}); end
        f_wr = 1'b1; f_wdata = 8'hA5;
        tick();
        f_wr = 1'b0;
        n_cmp++; if (f_rdata !== 8'hA5) begin n_err++; $display("FAIL fw_data: got %h want a5", f_rdata); end
        n_cmp++; if (f_rvalid !== 1'b1) begin n_err++; $display("FAIL fw_valid: got %b want 1", f_rvalid); end
        tick();
        n_cmp++; if (f_rdata !== 8'hA5) begin n_err++; $display("FAIL fw_hold: got %h want a5", f_rdata); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        n_cmp++; if (f_empty !== 1'b1) begin n_err++; $display("FAIL fw_empty: got %b want 1", f_empty); end
        n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL fw_valid0: got %b want 0", f_rvalid); end
        f_wr = 1'b1; f_wdata = 8'h3C;
        tick();
        f_wdata = 8'h7E;
        tick();
        f_wr = 1'b0;
        n_cmp++; if (f_rdata !== 8'h3C) begin n_err++; $display("FAIL fw_first: got %h want 3c", f_rdata); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        n_cmp++; if ({f_rvalid, f_rdata} !== 9'h17E) begin n_err++; $display("FAIL fw_second: got %b/%h want 1/7e", f_rvalid, f_rdata); end
    endtask

    initial begin
        rst = 1'b1;
        s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_wdata = 8'h00;
        f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_wdata = 8'h00;
        test_reset();
        test_fill_overflow();
        test_simultaneous();
        test_wrap();
        test_underflow();
        test_fwft();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
